// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between execute control and the multiply/divide sequencer.
// The master side issues MULT/DIV requests and MTHI/MTLO writes; the slave side
// returns the stall request, status flags and the HI/LO pair.
interface muldiv_sequencer_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 start;
    logic [1:0]           op;
    logic [DataWidth-1:0] operand_a;
    logic [DataWidth-1:0] operand_b;
    logic                 hi_write;
    logic                 lo_write;
    logic [DataWidth-1:0] write_data;

    logic                 stall;
    logic                 busy;
    logic                 done;
    logic [DataWidth-1:0] hi;
    logic [DataWidth-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, hi_write, lo_write, write_data,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, hi_write, lo_write, write_data,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO pair.
// Radix-2 shift-add multiply or restoring divide on operand magnitudes, one bit
// per cycle over DataWidth cycles, followed by a sign-fix/commit cycle.
// op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
module muldiv_sequencer #(
    parameter int unsigned DataWidth = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [CntW-1:0]      LastCnt = CntW'(DataWidth - 1);
    localparam logic [DataWidth-1:0] MinVal  = {1'b1, {(DataWidth - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DataWidth-1:0] hi_q, hi_d;
    logic [DataWidth-1:0] lo_q, lo_d;

    // opnd: multiplicand (mul) or divisor (div) magnitude.
    // shreg: multiplier shifting out / product low half (mul),
    //        dividend shifting out / quotient shifting in (div).
    // rem: product high half (mul) or partial remainder (div).
    logic [DataWidth-1:0] opnd_q, opnd_d;
    logic [DataWidth-1:0] shreg_q, shreg_d;
    logic [DataWidth-1:0] rem_q, rem_d;
    logic [DataWidth-1:0] orig_a_q, orig_a_d;
    logic                 is_div_q, is_div_d;
    logic                 res_neg_q, res_neg_d;
    logic                 a_neg_q, a_neg_d;
    logic                 div_zero_q, div_zero_d;
    logic                 ovf_q, ovf_d;

    // Operand decode for a new request.
    logic                 signed_op;
    logic                 in_a_neg;
    logic                 in_b_neg;
    logic [DataWidth-1:0] mag_a;
    logic [DataWidth-1:0] mag_b;

    // Datapath for one iteration and for the final fix-up.
    logic [DataWidth:0]     add_sum;
    logic [DataWidth:0]     shifted;
    logic [DataWidth:0]     trial;
    logic [2*DataWidth-1:0] prod;
    logic [2*DataWidth-1:0] prod_fix;
    logic [DataWidth-1:0]   quo_fix;
    logic [DataWidth-1:0]   rem_fix;

    // Decode request operands into magnitudes and sign flags.
    always_comb begin
        signed_op = ~bus.op[0];
        in_a_neg  = signed_op & bus.operand_a[DataWidth-1];
        in_b_neg  = signed_op & bus.operand_b[DataWidth-1];
        mag_a     = in_a_neg ? -bus.operand_a : bus.operand_a;
        mag_b     = in_b_neg ? -bus.operand_b : bus.operand_b;
    end

    // Iteration arithmetic and sign correction of the finished magnitudes.
    always_comb begin
        add_sum  = {1'b0, rem_q} + {1'b0, (shreg_q[0] ? opnd_q : {DataWidth{1'b0}})};
        shifted  = {rem_q, shreg_q[DataWidth-1]};
        // Bit DataWidth set means the trial subtraction went negative: restore.
        trial    = shifted - {1'b0, opnd_q};
        prod     = {rem_q, shreg_q};
        prod_fix = res_neg_q ? -prod : prod;
        quo_fix  = res_neg_q ? -shreg_q : shreg_q;
        rem_fix  = a_neg_q ? -rem_q : rem_q;
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        opnd_d     = opnd_q;
        shreg_d    = shreg_q;
        rem_d      = rem_q;
        orig_a_d   = orig_a_q;
        is_div_d   = is_div_q;
        res_neg_d  = res_neg_q;
        a_neg_d    = a_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    // Start takes priority; a coincident MTHI/MTLO is dropped.
                    state_d    = StRun;
                    count_d    = '0;
                    rem_d      = '0;
                    is_div_d   = bus.op[1];
                    a_neg_d    = in_a_neg;
                    res_neg_d  = in_a_neg ^ in_b_neg;
                    opnd_d     = bus.op[1] ? mag_b : mag_a;
                    shreg_d    = bus.op[1] ? mag_a : mag_b;
                    orig_a_d   = bus.operand_a;
                    div_zero_d = bus.op[1] && (bus.operand_b == '0);
                    ovf_d      = (bus.op == 2'b10) && (bus.operand_a == MinVal) &&
                                 (bus.operand_b == {DataWidth{1'b1}});
                end else begin
                    if (bus.hi_write) hi_d = bus.write_data;
                    if (bus.lo_write) lo_d = bus.write_data;
                end
            end

            StRun: begin
                if (is_div_q) begin
                    if (!trial[DataWidth]) begin
                        rem_d   = trial[DataWidth-1:0];
                        shreg_d = {shreg_q[DataWidth-2:0], 1'b1};
                    end else begin
                        rem_d   = shifted[DataWidth-1:0];
                        shreg_d = {shreg_q[DataWidth-2:0], 1'b0};
                    end
                end else begin
                    // Add-then-shift-right keeps the carry of the partial sum.
                    rem_d   = add_sum[DataWidth:1];
                    shreg_d = {add_sum[0], shreg_q[DataWidth-1:1]};
                end
                count_d = count_q + CntW'(1);
                if (count_q == LastCnt) begin
                    state_d = StFix;
                    count_d = '0;
                end
            end

            StFix: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*DataWidth-1:DataWidth];
                    lo_d = prod_fix[DataWidth-1:0];
                end else if (div_zero_q) begin
                    hi_d = orig_a_q;
                    lo_d = {DataWidth{1'b1}};
                end else if (ovf_q) begin
                    hi_d = '0;
                    lo_d = MinVal;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            shreg_q    <= '0;
            rem_q      <= '0;
            orig_a_q   <= '0;
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            a_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            opnd_q     <= opnd_d;
            shreg_q    <= shreg_d;
            rem_q      <= rem_d;
            orig_a_q   <= orig_a_d;
            is_div_q   <= is_div_d;
            res_neg_q  <= res_neg_d;
            a_neg_q    <= a_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    // Stall covers the accepting cycle combinationally, then every non-idle cycle.
    always_comb begin
        bus.stall = (state_q != StIdle) || ((state_q == StIdle) && bus.start);
        bus.busy  = busy_q;
        bus.done  = done_q;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a 64-bit arithmetic model.
module tb_muldiv_sequencer;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.DataWidth(W)) bus ();

    muldiv_sequencer #(.DataWidth(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result {hi, lo} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        int              ia;
        int              ib;
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        int              q;
        int              r;
        logic [63:0]     res;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = '0;
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    q   = ia / ib;
                    r   = ia % ib;
                    res = {r, q};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 9);
            4:       return -$urandom_range(1, 9);
            default: return $urandom;
        endcase
    endfunction

    // Issue one request from IDLE; poke_at >0 re-pulses Start and MTHI/MTLO mid-RUN.
    // chain=1 leaves the bench in the Done cycle so the next request starts there.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_at, input bit with_write, input bit chain);
        logic [63:0] exp;
        int          cycles;
        int          dones;
        bit          stable_ok;
        bit          busy_ok;
        exp = ref_model(op, a, b);
        bus.start      = 1'b1;
        bus.op         = op;
        bus.operand_a  = a;
        bus.operand_b  = b;
        bus.hi_write   = with_write;
        bus.lo_write   = with_write;
        bus.write_data = $urandom;
        #1;
        check_eq("stall_cycle0", {63'h0, bus.stall}, 64'h1);
        step();
        bus.start    = 1'b0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        cycles    = 1;
        dones     = 0;
        stable_ok = 1'b1;
        busy_ok   = 1'b1;
        while (bus.stall && cycles < 200) begin
            if (bus.done) dones++;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.hi !== m_hi || bus.lo !== m_lo) stable_ok = 1'b0;
            bus.start      = (cycles == poke_at);
            bus.hi_write   = (cycles == poke_at);
            bus.lo_write   = (cycles == poke_at);
            bus.op         = 2'($urandom);
            bus.write_data = $urandom;
            step();
            cycles++;
        end
        bus.start    = 1'b0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        check_eq("stall_len", 64'(cycles), 64'(W + 2));
        check_eq("busy_during_run", {63'h0, busy_ok}, 64'h1);
        check_eq("hilo_stable_run", {63'h0, stable_ok}, 64'h1);
        check_eq("no_early_done", 64'(dones), 64'h0);
        check_eq("done_pulse", {63'h0, bus.done}, 64'h1);
        check_eq("hi", {32'h0, bus.hi}, {32'h0, exp[63:32]});
        check_eq("lo", {32'h0, bus.lo}, {32'h0, exp[31:0]});
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        if (!chain) begin
            step();
            check_eq("done_one_cycle", {63'h0, bus.done}, 64'h0);
            check_eq("idle_after", {62'h0, bus.busy, bus.stall}, 64'h0);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.op         = 2'b00;
        bus.operand_a  = '0;
        bus.operand_b  = '0;
        bus.hi_write   = 1'b0;
        bus.lo_write   = 1'b0;
        bus.write_data = '0;
        m_hi = '0;
        m_lo = '0;
        rst  = 1'b1;
        step();
        step();
        check_eq("rst_hi", {32'h0, bus.hi}, 64'h0);
        check_eq("rst_lo", {32'h0, bus.lo}, 64'h0);
        check_eq("rst_flags", {61'h0, bus.busy, bus.done, bus.stall}, 64'h0);
        rst = 1'b0;
        step();

        // Directed cases.
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, 1'b0, 1'b0);
        check_eq("mult_hi_const", {32'h0, bus.hi}, 64'hFFFF_FFFF);
        check_eq("mult_lo_const", {32'h0, bus.lo}, 64'hFFFF_FFF1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check_eq("multu_hilo_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0, 1'b0);
        check_eq("div_trunc_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check_eq("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op(2'b11, 32'h1234_5678, 32'h0, 7, 1'b0, 1'b0);
        check_eq("divu_zero_const", {bus.hi, bus.lo}, 64'h1234_5678_FFFF_FFFF);
        run_op(2'b10, 32'h8765_4321, 32'h0, 0, 1'b1, 1'b1);
        run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0, 1'b0);

        // Randomized requests, some back-to-back, some with mid-run pokes.
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom), pick_operand(), pick_operand(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        step();

        // Reset during RUN cycle 10 aborts with HI/LO cleared and no Done.
        bus.start     = 1'b1;
        bus.op        = 2'b01;
        bus.operand_a = 32'hDEAD_BEEF;
        bus.operand_b = 32'h1234_5678;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        rst = 1'b1;
        step();
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check_eq("abort_hi", {32'h0, bus.hi}, 64'h0);
        check_eq("abort_lo", {32'h0, bus.lo}, 64'h0);
        check_eq("abort_flags", {61'h0, bus.busy, bus.done, bus.stall}, 64'h0);
        begin
            int late_done;
            late_done = 0;
            for (int c = 0; c < W + 4; c++) begin
                if (bus.done || bus.busy) late_done++;
                step();
            end
            check_eq("abort_no_done", 64'(late_done), 64'h0);
        end

        // MTHI / MTLO writes.
        bus.hi_write   = 1'b1;
        bus.write_data = 32'hCAFE_F00D;
        step();
        bus.hi_write = 1'b0;
        check_eq("mthi_hi", {32'h0, bus.hi}, 64'hCAFE_F00D);
        check_eq("mthi_lo_kept", {32'h0, bus.lo}, 64'h0);
        bus.lo_write   = 1'b1;
        bus.write_data = 32'h0BAD_CAFE;
        step();
        bus.lo_write = 1'b0;
        check_eq("mtlo_both", {bus.hi, bus.lo}, 64'hCAFE_F00D_0BAD_CAFE);
        bus.hi_write   = 1'b1;
        bus.lo_write   = 1'b1;
        bus.write_data = 32'h5A5A_A5A5;
        step();
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        check_eq("mt_both", {bus.hi, bus.lo}, 64'h5A5A_A5A5_5A5A_A5A5);
        m_hi = 32'h5A5A_A5A5;
        m_lo = 32'h5A5A_A5A5;
        run_op(2'b11, 32'hFFFF_FFF0, 32'h0000_0007, 3, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller that sits beside the Execute-stage ALU and owns the HI/LO register pair. It accepts MULT, MULTU, DIV and DIVU requests from decode/execute control and runs a radix-2 shift-add or restoring-divide sequence over DATA_WIDTH cycles. While the sequence runs it holds the pipeline stall line high, then commits HI/LO and pulses Done. It also services MTHI/MTLO writes and drives HI/LO continuously for MFHI/MFLO.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; the iteration count equals DATA_WIDTH.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high.
- Start  input  1  request; sampled only in IDLE.
- Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OperandA  input  DATA_WIDTH  rs value: multiplicand or dividend.
- OperandB  input  DATA_WIDTH  rt value: multiplier or divisor.
- HiWrite  input  1  MTHI strobe.
- LoWrite  input  1  MTLO strobe.
- WriteData  input  DATA_WIDTH  MTHI/MTLO data.
- Stall  output  1  combinational pipeline freeze request.
- Busy  output  1  registered; high whenever state ≠ IDLE.
- Done  output  1  registered one-cycle completion pulse.
- Hi  output  DATA_WIDTH  HI register.
- Lo  output  DATA_WIDTH  LO register.

## Operation
**Reset.** Reset forces the following values at the next edge:
- state IDLE
- Hi = 0, Lo = 0
- Busy = 0, Done = 0
- iteration counter = 0
- internal accumulator and shift registers = 0

**FSM states.**
- IDLE
  - Start=1 → latch operands; go to RUN.
  - Otherwise, apply HiWrite/LoWrite from WriteData.
- RUN
  - One iteration per cycle; counter counts 0..DATA_WIDTH-1.
  - At the last iteration → FIX.
- FIX
  - Apply sign correction.
  - Write Hi and Lo; set Done; go to IDLE.

**Operand handling.**
- Signed ops (MULT, DIV): latch |A| and |B|.
- Record the result sign (A[msb] XOR B[msb]) and the dividend sign.
- Unsigned ops: use operands as-is.

**Multiply.**
- Shift-add on magnitudes into a 2·DATA_WIDTH product.
- In FIX, negate the product (two's complement over 2·DATA_WIDTH) if the result sign is 1.
- Hi = product upper half; Lo = product lower half.

**Divide.**
- Restoring division on magnitudes; quotient truncates toward zero.
- In FIX:
  - Negate the quotient if the result sign is 1.
  - Negate the remainder if the dividend was negative.
- Lo = quotient; Hi = remainder.

**Divide by zero (DIV or DIVU, B=0).**
- Full latency.
- Lo = all ones; Hi = OperandA as latched (original signed value, not the magnitude).

**Signed overflow (DIV, −2^(W−1) / −1).**
- Lo = 0x80000000; Hi = 0.

**Start while Busy.**
- Ignored; the request is not queued.

**HiWrite/LoWrite while Busy.**
- Ignored.

**HiWrite/LoWrite and Start in the same IDLE cycle.**
- Start wins; the write is dropped.
- The pipeline guarantees the two never coincide legally.

**HiWrite and LoWrite together.**
- Both registers load WriteData.

**Reset mid-operation.**
- Abort immediately: IDLE, Hi = Lo = 0, no Done.

## Timing
**Cycle 0.** IDLE with Start=1.
- Stall = 1 (combinational: Start && IDLE, OR state ≠ IDLE).
- At edge E0, operands are latched and the state becomes RUN.

**Cycles 1..DATA_WIDTH.** RUN (32 cycles at the default width).
- Busy = 1, Stall = 1.

**Cycle DATA_WIDTH+1.** FIX.
- Stall = 1.
- At the closing edge, Hi/Lo are written and Done is set.

**Cycle DATA_WIDTH+2.** IDLE.
- Done = 1 for exactly one cycle; Stall = 0.
- Hi/Lo hold the new values.
- A new Start is accepted in this same cycle.

**Summary.**
- Stall is high for DATA_WIDTH+2 consecutive cycles: 34 at the default width.
- Result latency from Start to Hi/Lo visible is DATA_WIDTH+2 cycles.

**Other timing rules.**
- Hi and Lo change only at FIX commit, on an IDLE write, or on Reset; they are stable during RUN.
- MTHI/MTLO: the written value is visible on Hi/Lo the cycle after the strobe.

## Test plan
- **MULT.** A=0xFFFFFFFD (−3), B=5 → after 34 stall cycles: Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Done high for one cycle; Stall drops the same cycle.
- **MULTU.** A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001.
- **DIV, truncation toward zero.** A=0xFFFFFFF9 (−7), B=2 → Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1).
- **DIV, overflow.** A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- **DIVU by zero and Busy behaviour.**
  - A=0x12345678, B=0 → Lo=0xFFFFFFFF, Hi=0x12345678.
  - Start pulsed again mid-RUN → ignored; exactly one Done.
- **Reset and MTHI/MTLO.**
  - Reset asserted in RUN cycle 10 → next cycle Hi=Lo=0, Busy=0, Stall=0, no Done.
  - Then HiWrite with WriteData=0xCAFEF00D in IDLE → Hi=0xCAFEF00D the next cycle; Lo unchanged.
